rf_wb_sched: RTL and testbench
==============================

# rf_wb_sched

Register-file write-back scheduler and hazard scoreboard for the RV64 integer pipeline. It tracks which architectural registers have a write in flight and stalls issue on any RAW/WAW hazard. It also shares the register file's single write port between the ALU and LSU write-back requesters with round-robin arbitration. It sits between the issue stage, the two execution units, and the register file write port.

## Interface
Parameters:
- `XLEN`, 64: data width; equals `CPU_WIDTH`.
- `AW`, 5: register address width; equals `REG_ADDRW`; 2**AW registers.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `iss_valid`  in  1  issue stage offers an instruction.
- `iss_ready`  out  1  instruction may issue this cycle.
- `iss_rs1`, `iss_rs2`  in  AW  source registers.
- `iss_rs1_en`, `iss_rs2_en`  in  1  source is actually read.
- `iss_rd`  in  AW  destination register.
- `iss_rd_en`  in  1  instruction writes `rd`.
- `flush`  in  1  pipeline flush; clears the scoreboard.
- `alu_valid`, `lsu_valid`  in  1  write-back request.
- `alu_ready`, `lsu_ready`  out  1  write-back grant.
- `alu_addr`, `lsu_addr`  in  AW  write-back destination.
- `alu_data`, `lsu_data`  in  XLEN  write-back data.
- `rf_wen`  out  1  register file write enable.
- `rf_waddr`  out  AW  register file write address.
- `rf_wdata`  out  XLEN  register file write data.
- `busy`  out  2**AW  scoreboard bit vector, for debug and forwarding.
- `wb_err`  out  1  sticky protocol error.
- `stall_cnt`  out  32  count of issue-stall cycles.

## Operation
- Scoreboard `busy[i]` means register i has a write issued but not yet written back. `busy[0]` is constantly 0.
- Hazard: a hazard exists when any of the following hold, using registered `busy` only (no same-cycle release):
  - `iss_rs1_en & busy[iss_rs1]`
  - `iss_rs2_en & busy[iss_rs2]`
  - `iss_rd_en & busy[iss_rd]`
- `iss_ready` = !hazard & !flush.
- Issue handshake is `iss_valid & iss_ready`. On a handshake with `iss_rd_en` and `iss_rd` != 0, `busy[iss_rd]` is set at the next edge.
- Arbitration uses the registered `last` bit (0 = ALU granted last):
  - Only one requester valid: it is granted.
  - Both valid: the requester not equal to `last` is granted.
  - `last` updates only on a grant.
  - `alu_ready` / `lsu_ready` are the combinational grant.
  - Requesters hold valid, addr and data stable until granted.
- Write port: `rf_wen` = grant & granted addr != 0. `rf_waddr` and `rf_wdata` are muxed from the winner; they are 0 when there is no grant. A granted write to x0 completes the handshake with no write.
- On grant, `busy[addr]` is cleared at the next edge. The WAW stall guarantees set and clear never target the same register in one cycle.
- Protocol error: a grant to addr != 0 with `busy[addr]` == 0 sets `wb_err`. The write still occurs. `wb_err` clears only on reset.
- Flush: `busy` goes to all-zero at the next edge, overriding same-cycle sets and clears. Write-back grants in the flush cycle proceed normally.
- `stall_cnt` increments each cycle `iss_valid & !iss_ready` and saturates at 0xFFFF_FFFF.

## Timing
- Reset (asynchronous, immediate): `busy`=0, `last`=1 (so ALU wins the first tie), `wb_err`=0, `stall_cnt`=0. Every output therefore resets as follows:
  - `iss_ready`=1 unless inputs hazard or `flush`.
  - `rf_wen`=0 with no request.
  - `busy`=0, `wb_err`=0, `stall_cnt`=0.
- Reset asserted mid-operation discards all pending scoreboard state.
- Grant to `rf_wen` has zero latency (same cycle). The register file write lands at that edge.
- An instruction depending on a register is issuable in the cycle after that register's write-back grant: a one-cycle minimum bubble.
- Issue set to visible `busy`: one cycle.

## Structure
- The shared package holds:
  - `XLEN`/`AW` defaults, tied to `CPU_WIDTH`/`REG_ADDRW`/`REG_COUNT`.
  - The `wb_req_t` struct {valid, addr, data}.
  - The requester index enum (`WB_ALU`=0, `WB_LSU`=1).
- Sub-module `rr_arb2`: two-input round-robin arbiter holding the `last` register. Its outputs are a one-hot grant plus grant index.
- The scoreboard and counter stay in the top module.

## Test plan
- Reset, then issue `rd`=5 and hold: `busy[5]`=1 next cycle. A dependent instruction with rs1=5 sees `iss_ready`=0 and `stall_cnt` counts. ALU write-back addr 5, data 0xDEAD gives `rf_wen`=1, `rf_waddr`=5. Next cycle `iss_ready`=1.
- Busy x3 and x4, then ALU (addr 3) and LSU (addr 4) both valid for 2 cycles: grants go ALU then LSU. A subsequent tie grants ALU again (alternation).
- Issue with `rd`=0: busy stays 0. ALU write-back addr 0 gives `alu_ready`=1 and `rf_wen`=0.
- `busy[7]`=1 and a same-`rd`=7 issue is attempted: `iss_ready`=0 (WAW). After write-back of 7 it issues and `busy[7]` is set again.
- Write-back to non-busy x9: write occurs, `wb_err`=1 and stays 1 until `rst_n` low.
- Busy x1, x2, then assert `flush` with a simultaneous issue of rd=6: `iss_ready`=0 and `busy`=0 next cycle. Assert `rst_n` low mid-stall: all outputs return to reset values immediately.

Source files
------------

// File: rtl/rf_wb_sched_pkg.sv
// Shared definitions for the register-file write-back scheduler.
//   CPU_WIDTH / REG_ADDRW / REG_COUNT : integer pipeline geometry
//   XLEN_DEFAULT / AW_DEFAULT         : parameter defaults for rf_wb_sched
//   wb_req_t                          : one write-back request {valid, addr, data}
//   wb_src_e                          : write-back requester index (ALU / LSU)
package rf_wb_sched_pkg;

  localparam int CPU_WIDTH = 64;
  localparam int REG_ADDRW = 5;
  localparam int REG_COUNT = 2 ** REG_ADDRW;

  localparam int XLEN_DEFAULT = CPU_WIDTH;
  localparam int AW_DEFAULT   = REG_ADDRW;

  typedef struct packed {
    logic                 valid;
    logic [REG_ADDRW-1:0] addr;
    logic [CPU_WIDTH-1:0] data;
  } wb_req_t;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_LSU = 1'b1
  } wb_src_e;

endpackage

// File: rtl/rf_wb_sched_rr_arb2.sv
// Two-input round-robin arbiter for the register-file write port.
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : request vector, bit index = wb_src_e
//   gnt[1:0]   : one-hot grant (combinational)
//   gnt_idx    : index of the granted requester
//   gnt_valid  : some requester is granted this cycle
// The "last" register remembers who won most recently; it resets to LSU so
// the ALU wins the first tie.
module rr_arb2
  import rf_wb_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output wb_src_e    gnt_idx,
  output logic       gnt_valid
);

  wb_src_e last_q;
  wb_src_e last_d;

  always_comb begin
    gnt_idx   = WB_ALU;
    gnt_valid = 1'b0;
    gnt       = 2'b00;
    if (req == 2'b11) begin
      // Tie: whoever did not win last time goes now.
      gnt_idx   = (last_q == WB_ALU) ? WB_LSU : WB_ALU;
      gnt_valid = 1'b1;
    end else if (req[WB_ALU]) begin
      gnt_idx   = WB_ALU;
      gnt_valid = 1'b1;
    end else if (req[WB_LSU]) begin
      gnt_idx   = WB_LSU;
      gnt_valid = 1'b1;
    end
    if (gnt_valid) begin
      gnt[gnt_idx] = 1'b1;
    end
    last_d = gnt_valid ? gnt_idx : last_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= WB_LSU;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/rf_wb_sched.sv
// Register-file write-back scheduler and hazard scoreboard.
//   Issue side : iss_valid/iss_ready handshake, rs1/rs2/rd with enables;
//                stalls on any RAW/WAW hazard against the registered scoreboard.
//   Write-back : ALU and LSU requesters share one register-file write port
//                through a round-robin arbiter; alu_ready/lsu_ready are grants.
//   Register file port : rf_wen / rf_waddr / rf_wdata (zero-latency from grant).
//   Debug      : busy (scoreboard), wb_err (sticky), stall_cnt (saturating).
//   flush clears the scoreboard at the next edge; rst_n resets everything.
module rf_wb_sched
  import rf_wb_sched_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int AW   = AW_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iss_valid,
  output logic              iss_ready,
  input  logic [AW-1:0]     iss_rs1,
  input  logic [AW-1:0]     iss_rs2,
  input  logic              iss_rs1_en,
  input  logic              iss_rs2_en,
  input  logic [AW-1:0]     iss_rd,
  input  logic              iss_rd_en,
  input  logic              flush,
  input  logic              alu_valid,
  input  logic              lsu_valid,
  output logic              alu_ready,
  output logic              lsu_ready,
  input  logic [AW-1:0]     alu_addr,
  input  logic [AW-1:0]     lsu_addr,
  input  logic [XLEN-1:0]   alu_data,
  input  logic [XLEN-1:0]   lsu_data,
  output logic              rf_wen,
  output logic [AW-1:0]     rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic [2**AW-1:0]  busy,
  output logic              wb_err,
  output logic [31:0]       stall_cnt
);

  localparam int NREG = 2 ** AW;

  logic [NREG-1:0] busy_q, busy_d;
  logic            wb_err_q, wb_err_d;
  logic [31:0]     stall_cnt_q, stall_cnt_d;

  wb_req_t  alu_req, lsu_req, win_req;
  logic [1:0] gnt;
  wb_src_e  gnt_idx;
  logic     gnt_valid;
  logic     wb_fire;
  logic     hazard;
  logic     iss_fire;

  assign alu_req = '{valid: alu_valid, addr: alu_addr, data: alu_data};
  assign lsu_req = '{valid: lsu_valid, addr: lsu_addr, data: lsu_data};

  rr_arb2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       ({lsu_req.valid, alu_req.valid}),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  assign alu_ready = gnt[WB_ALU];
  assign lsu_ready = gnt[WB_LSU];
  assign win_req   = (gnt_idx == WB_LSU) ? lsu_req : alu_req;
  assign wb_fire   = gnt_valid & win_req.valid;

  // Write port: a granted write to x0 consumes the grant but never writes.
  always_comb begin
    rf_wen   = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (wb_fire) begin
      rf_wen   = (win_req.addr != '0);
      rf_waddr = win_req.addr;
      rf_wdata = win_req.data;
    end
  end

  // Hazards look only at the registered scoreboard, so a register released
  // by a grant this cycle is still seen as busy: one-cycle bubble.
  always_comb begin
    hazard = (iss_rs1_en & busy_q[iss_rs1]) |
             (iss_rs2_en & busy_q[iss_rs2]) |
             (iss_rd_en  & busy_q[iss_rd]);
    iss_ready = ~hazard & ~flush;
    iss_fire  = iss_valid & iss_ready;
  end

  // Scoreboard next state. The WAW stall keeps set and clear apart, so the
  // order of clear-then-set only matters for protocol-violating traffic.
  // Flush overrides everything.
  always_comb begin
    busy_d = busy_q;
    if (wb_fire) begin
      busy_d[win_req.addr] = 1'b0;
    end
    if (iss_fire && iss_rd_en && (iss_rd != '0)) begin
      busy_d[iss_rd] = 1'b1;
    end
    if (flush) begin
      busy_d = '0;
    end
    busy_d[0] = 1'b0;
  end

  // Sticky error: a real write to a register the scoreboard never reserved.
  always_comb begin
    wb_err_d = wb_err_q;
    if (wb_fire && (win_req.addr != '0) && !busy_q[win_req.addr]) begin
      wb_err_d = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (iss_valid && !iss_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= '0;
      wb_err_q    <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      busy_q      <= busy_d;
      wb_err_q    <= wb_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign busy      = busy_q;
  assign wb_err    = wb_err_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_rf_wb_sched.sv
// Self-checking bench for rf_wb_sched: directed scenarios plus a randomized
// run checked against a behavioural reference model.
module tb_rf_wb_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iss_valid, iss_ready;
  logic [4:0]  iss_rs1, iss_rs2, iss_rd;
  logic        iss_rs1_en, iss_rs2_en, iss_rd_en;
  logic        flush;
  logic        alu_valid, lsu_valid, alu_ready, lsu_ready;
  logic [4:0]  alu_addr, lsu_addr;
  logic [63:0] alu_data, lsu_data;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic [31:0] busy;
  logic        wb_err;
  logic [31:0] stall_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state
  logic [31:0] m_busy;
  logic        m_last_lsu;
  logic        m_err;
  logic [31:0] m_stall;

  // Model predictions for the current cycle
  logic        e_ready, e_alu_rdy, e_lsu_rdy, e_wen;
  logic [4:0]  e_waddr;
  logic [63:0] e_wdata;

  always #5 clk = ~clk;

  rf_wb_sched dut (
    .clk(clk), .rst_n(rst_n),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .iss_rs1_en(iss_rs1_en), .iss_rs2_en(iss_rs2_en),
    .iss_rd(iss_rd), .iss_rd_en(iss_rd_en),
    .flush(flush),
    .alu_valid(alu_valid), .lsu_valid(lsu_valid),
    .alu_ready(alu_ready), .lsu_ready(lsu_ready),
    .alu_addr(alu_addr), .lsu_addr(lsu_addr),
    .alu_data(alu_data), .lsu_data(lsu_data),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy(busy), .wb_err(wb_err), .stall_cnt(stall_cnt)
  );

  task automatic idle();
    iss_valid = 0; iss_rs1 = 0; iss_rs2 = 0; iss_rd = 0;
    iss_rs1_en = 0; iss_rs2_en = 0; iss_rd_en = 0; flush = 0;
    alu_valid = 0; lsu_valid = 0; alu_addr = 0; lsu_addr = 0;
    alu_data = 0; lsu_data = 0;
  endtask

  // Advance one clock; inputs are changed and outputs sampled at negedge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    m_busy = 0; m_last_lsu = 1; m_err = 0; m_stall = 0;
  endtask

  task automatic issue_rd(input logic [4:0] rd);
    iss_valid = 1; iss_rd_en = 1; iss_rd = rd;
    tick();
    idle();
  endtask

  // Expected combinational behaviour from the model's registered state.
  task automatic predict();
    logic        any;
    logic        pick_lsu;
    e_ready = !((iss_rs1_en && m_busy[iss_rs1]) || (iss_rs2_en && m_busy[iss_rs2]) ||
                (iss_rd_en && m_busy[iss_rd])) && !flush;
    any = alu_valid || lsu_valid;
    if (alu_valid && lsu_valid) pick_lsu = !m_last_lsu;
    else                        pick_lsu = lsu_valid;
    e_alu_rdy = any && !pick_lsu;
    e_lsu_rdy = any && pick_lsu;
    e_waddr   = !any ? 5'd0  : (pick_lsu ? lsu_addr : alu_addr);
    e_wdata   = !any ? 64'd0 : (pick_lsu ? lsu_data : alu_data);
    e_wen     = any && (e_waddr != 0);
  endtask

  // Apply one clock edge to the model, using the predictions for this cycle.
  task automatic model_edge();
    if (e_alu_rdy || e_lsu_rdy) begin
      if (e_waddr != 0 && !m_busy[e_waddr]) m_err = 1;
      m_busy[e_waddr] = 0;
      m_last_lsu = e_lsu_rdy;
    end
    if (iss_valid && e_ready && iss_rd_en && iss_rd != 0) m_busy[iss_rd] = 1;
    if (flush) m_busy = 0;
    m_busy[0] = 0;
    if (iss_valid && !e_ready && m_stall != 32'hFFFF_FFFF) m_stall++;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    #1;
    tests_run++;
    if (busy !== 0 || wb_err !== 0 || stall_cnt !== 0) begin
      tests_failed++;
      $display("[TB] FAIL reset_state busy=%h wb_err=%b stall=%0d expected 0/0/0", busy, wb_err, stall_cnt);
    end
    tests_run++;
    if (iss_ready !== 1 || rf_wen !== 0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs iss_ready=%b rf_wen=%b expected 1/0", iss_ready, rf_wen);
    end
    do_reset();
  endtask

  task automatic test_raw();
    do_reset();
    issue_rd(5);
    tests_run++;
    if (busy !== 32'h0000_0020) begin
      tests_failed++;
      $display("[TB] FAIL raw_busy5 got %h expected 00000020", busy);
    end
    iss_valid = 1; iss_rs1_en = 1; iss_rs1 = 5;
    #1;
    tests_run++;
    if (iss_ready !== 0) begin
      tests_failed++;
      $display("[TB] FAIL raw_stall iss_ready got %b expected 0", iss_ready);
    end
    tick();
    tests_run++;
    if (stall_cnt !== 1) begin
      tests_failed++;
      $display("[TB] FAIL raw_stall_cnt got %0d expected 1", stall_cnt);
    end
    alu_valid = 1; alu_addr = 5; alu_data = 64'hDEAD;
    #1;
    tests_run++;
    if (rf_wen !== 1 || rf_waddr !== 5 || rf_wdata !== 64'hDEAD || alu_ready !== 1 || iss_ready !== 0) begin
      tests_failed++;
      $display("[TB] FAIL raw_wb wen=%b addr=%0d data=%h alu_ready=%b iss_ready=%b expected 1/5/dead/1/0",
               rf_wen, rf_waddr, rf_wdata, alu_ready, iss_ready);
    end
    tick();
    alu_valid = 0;
    #1;
    tests_run++;
    if (iss_ready !== 1 || busy !== 0 || stall_cnt !== 2) begin
      tests_failed++;
      $display("[TB] FAIL raw_release iss_ready=%b busy=%h stall=%0d expected 1/0/2", iss_ready, busy, stall_cnt);
    end
    idle();
  endtask

  task automatic test_arbitration();
    do_reset();
    issue_rd(3);
    issue_rd(4);
    alu_valid = 1; alu_addr = 3; alu_data = 64'h33;
    lsu_valid = 1; lsu_addr = 4; lsu_data = 64'h44;
    #1;
    tests_run++;
    if (alu_ready !== 1 || lsu_ready !== 0 || rf_waddr !== 3 || rf_wdata !== 64'h33) begin
      tests_failed++;
      $display("[TB] FAIL arb_first alu=%b lsu=%b addr=%0d expected 1/0/3", alu_ready, lsu_ready, rf_waddr);
    end
    tick();
    alu_addr = 0; alu_data = 64'h1;
    #1;
    tests_run++;
    if (alu_ready !== 0 || lsu_ready !== 1 || rf_waddr !== 4 || rf_wdata !== 64'h44) begin
      tests_failed++;
      $display("[TB] FAIL arb_second alu=%b lsu=%b addr=%0d expected 0/1/4", alu_ready, lsu_ready, rf_waddr);
    end
    tick();
    lsu_addr = 0;
    #1;
    tests_run++;
    if (alu_ready !== 1 || lsu_ready !== 0) begin
      tests_failed++;
      $display("[TB] FAIL arb_alternate alu=%b lsu=%b expected 1/0", alu_ready, lsu_ready);
    end
    tick();
    idle();
    tests_run++;
    if (busy !== 0 || wb_err !== 0) begin
      tests_failed++;
      $display("[TB] FAIL arb_final busy=%h wb_err=%b expected 0/0", busy, wb_err);
    end
  endtask

  task automatic test_x0();
    do_reset();
    issue_rd(0);
    tests_run++;
    if (busy !== 0) begin
      tests_failed++;
      $display("[TB] FAIL x0_busy got %h expected 0", busy);
    end
    alu_valid = 1; alu_addr = 0; alu_data = 64'hFF;
    #1;
    tests_run++;
    if (alu_ready !== 1 || rf_wen !== 0) begin
      tests_failed++;
      $display("[TB] FAIL x0_wb alu_ready=%b rf_wen=%b expected 1/0", alu_ready, rf_wen);
    end
    tick();
    idle();
    tests_run++;
    if (wb_err !== 0) begin
      tests_failed++;
      $display("[TB] FAIL x0_err got %b expected 0", wb_err);
    end
  endtask

  task automatic test_waw();
    do_reset();
    issue_rd(7);
    iss_valid = 1; iss_rd_en = 1; iss_rd = 7;
    #1;
    tests_run++;
    if (iss_ready !== 0) begin
      tests_failed++;
      $display("[TB] FAIL waw_stall iss_ready got %b expected 0", iss_ready);
    end
    tick();
    lsu_valid = 1; lsu_addr = 7; lsu_data = 64'h77;
    #1;
    tests_run++;
    if (iss_ready !== 0 || lsu_ready !== 1 || rf_waddr !== 7) begin
      tests_failed++;
      $display("[TB] FAIL waw_wb iss_ready=%b lsu_ready=%b addr=%0d expected 0/1/7", iss_ready, lsu_ready, rf_waddr);
    end
    tick();
    lsu_valid = 0;
    #1;
    tests_run++;
    if (iss_ready !== 1) begin
      tests_failed++;
      $display("[TB] FAIL waw_release iss_ready got %b expected 1", iss_ready);
    end
    tick();
    idle();
    tests_run++;
    if (busy !== 32'h0000_0080) begin
      tests_failed++;
      $display("[TB] FAIL waw_reissue busy got %h expected 00000080", busy);
    end
  endtask

  task automatic test_wb_err();
    do_reset();
    alu_valid = 1; alu_addr = 9; alu_data = 64'h99;
    #1;
    tests_run++;
    if (rf_wen !== 1 || rf_waddr !== 9) begin
      tests_failed++;
      $display("[TB] FAIL err_write rf_wen=%b addr=%0d expected 1/9", rf_wen, rf_waddr);
    end
    tick();
    idle();
    repeat (3) tick();
    tests_run++;
    if (wb_err !== 1) begin
      tests_failed++;
      $display("[TB] FAIL err_sticky got %b expected 1", wb_err);
    end
    rst_n = 0;
    #1;
    tests_run++;
    if (wb_err !== 0) begin
      tests_failed++;
      $display("[TB] FAIL err_reset got %b expected 0", wb_err);
    end
    do_reset();
  endtask

  task automatic test_flush_reset();
    do_reset();
    issue_rd(1);
    issue_rd(2);
    tests_run++;
    if (busy !== 32'h0000_0006) begin
      tests_failed++;
      $display("[TB] FAIL flush_pre busy got %h expected 00000006", busy);
    end
    flush = 1; iss_valid = 1; iss_rd_en = 1; iss_rd = 6;
    #1;
    tests_run++;
    if (iss_ready !== 0) begin
      tests_failed++;
      $display("[TB] FAIL flush_ready got %b expected 0", iss_ready);
    end
    tick();
    idle();
    tests_run++;
    if (busy !== 0 || stall_cnt !== 1) begin
      tests_failed++;
      $display("[TB] FAIL flush_clear busy=%h stall=%0d expected 0/1", busy, stall_cnt);
    end
    issue_rd(5);
    iss_valid = 1; iss_rs1_en = 1; iss_rs1 = 5;
    repeat (2) tick();
    tests_run++;
    if (stall_cnt !== 3 || busy !== 32'h0000_0020) begin
      tests_failed++;
      $display("[TB] FAIL midstall stall=%0d busy=%h expected 3/00000020", stall_cnt, busy);
    end
    #2 rst_n = 0;
    #1;
    tests_run++;
    if (busy !== 0 || stall_cnt !== 0 || wb_err !== 0 || iss_ready !== 1 || rf_wen !== 0) begin
      tests_failed++;
      $display("[TB] FAIL async_reset busy=%h stall=%0d err=%b ready=%b wen=%b expected 0/0/0/1/0",
               busy, stall_cnt, wb_err, iss_ready, rf_wen);
    end
    do_reset();
  endtask

  task automatic test_random();
    logic alu_pend, lsu_pend;
    do_reset();
    alu_pend = 0; lsu_pend = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      // New write-back requests target registers that are reserved and not
      // already claimed by the other requester; occasionally x0.
      if (!alu_pend && ($urandom_range(0, 2) == 0)) begin
        for (int t = 0; t < 8 && !alu_pend; t++) begin
          logic [4:0] r;
          r = 5'($urandom_range(1, 31));
          if (m_busy[r] && !(lsu_pend && lsu_addr == r)) begin
            alu_pend = 1; alu_addr = r;
          end
        end
        if (!alu_pend && ($urandom_range(0, 3) == 0)) begin
          alu_pend = 1; alu_addr = 0;
        end
        alu_data = {$urandom, $urandom};
      end
      if (!lsu_pend && ($urandom_range(0, 2) == 0)) begin
        for (int t = 0; t < 8 && !lsu_pend; t++) begin
          logic [4:0] r;
          r = 5'($urandom_range(1, 31));
          if (m_busy[r] && !(alu_pend && alu_addr == r)) begin
            lsu_pend = 1; lsu_addr = r;
          end
        end
        if (!lsu_pend && ($urandom_range(0, 3) == 0)) begin
          lsu_pend = 1; lsu_addr = 0;
        end
        lsu_data = {$urandom, $urandom};
      end
      alu_valid = alu_pend;
      lsu_valid = lsu_pend;
      iss_valid  = ($urandom_range(0, 1) == 1);
      iss_rs1    = 5'($urandom); iss_rs1_en = ($urandom_range(0, 1) == 1);
      iss_rs2    = 5'($urandom); iss_rs2_en = ($urandom_range(0, 1) == 1);
      iss_rd     = 5'($urandom); iss_rd_en  = ($urandom_range(0, 3) != 0);
      #1;
      predict();
      tests_run++;
      if (iss_ready !== e_ready || alu_ready !== e_alu_rdy || lsu_ready !== e_lsu_rdy) begin
        tests_failed++;
        $display("[TB] FAIL rand_hs cyc=%0d ready/alu/lsu got %b%b%b expected %b%b%b",
                 cyc, iss_ready, alu_ready, lsu_ready, e_ready, e_alu_rdy, e_lsu_rdy);
      end
      tests_run++;
      if (rf_wen !== e_wen || rf_waddr !== e_waddr || rf_wdata !== e_wdata) begin
        tests_failed++;
        $display("[TB] FAIL rand_port cyc=%0d got %b/%0d/%h expected %b/%0d/%h",
                 cyc, rf_wen, rf_waddr, rf_wdata, e_wen, e_waddr, e_wdata);
      end
      @(posedge clk);
      model_edge();
      if (e_alu_rdy) alu_pend = 0;
      if (e_lsu_rdy) lsu_pend = 0;
      @(negedge clk);
      tests_run++;
      if (busy !== m_busy || wb_err !== m_err || stall_cnt !== m_stall) begin
        tests_failed++;
        $display("[TB] FAIL rand_state cyc=%0d busy=%h err=%b stall=%0d expected %h/%b/%0d",
                 cyc, busy, wb_err, stall_cnt, m_busy, m_err, m_stall);
      end
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_raw();
    test_arbitration();
    test_x0();
    test_waw();
    test_wb_err();
    test_flush_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
